// File: rtl/lio_axi_ost_limiter.sv
// AXI4 pass-through that bounds outstanding read/write bursts and holds W beats
// until their AW has been accepted, ahead of the AXI clock-domain-crossing bridge.
module lio_axi_ost_limiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH/8,
  parameter int unsigned MAX_WR_OST = 4,
  parameter int unsigned MAX_RD_OST = 4
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [ID_WIDTH-1:0]   axis_awid,
  input  logic [ADDR_WIDTH-1:0] axis_awaddr,
  input  logic [7:0]            axis_awlen,
  input  logic [2:0]            axis_awsize,
  input  logic [1:0]            axis_awburst,
  input  logic                  axis_awlock,
  input  logic [3:0]            axis_awcache,
  input  logic [2:0]            axis_awprot,
  input  logic [3:0]            axis_awqos,
  input  logic [3:0]            axis_awregion,
  input  logic                  axis_awvalid,
  output logic                  axis_awready,
  input  logic [ID_WIDTH-1:0]   axis_wid,
  input  logic [DATA_WIDTH-1:0] axis_wdata,
  input  logic [STRB_WIDTH-1:0] axis_wstrb,
  input  logic                  axis_wlast,
  input  logic                  axis_wvalid,
  output logic                  axis_wready,
  output logic [ID_WIDTH-1:0]   axis_bid,
  output logic [1:0]            axis_bresp,
  output logic                  axis_bvalid,
  input  logic                  axis_bready,
  input  logic [ID_WIDTH-1:0]   axis_arid,
  input  logic [ADDR_WIDTH-1:0] axis_araddr,
  input  logic [7:0]            axis_arlen,
  input  logic [2:0]            axis_arsize,
  input  logic [1:0]            axis_arburst,
  input  logic                  axis_arlock,
  input  logic [3:0]            axis_arcache,
  input  logic [2:0]            axis_arprot,
  input  logic [3:0]            axis_arqos,
  input  logic [3:0]            axis_arregion,
  input  logic                  axis_arvalid,
  output logic                  axis_arready,
  output logic [ID_WIDTH-1:0]   axis_rid,
  output logic [DATA_WIDTH-1:0] axis_rdata,
  output logic [1:0]            axis_rresp,
  output logic                  axis_rlast,
  output logic                  axis_rvalid,
  input  logic                  axis_rready,
  output logic [ID_WIDTH-1:0]   axim_awid,
  output logic [ADDR_WIDTH-1:0] axim_awaddr,
  output logic [7:0]            axim_awlen,
  output logic [2:0]            axim_awsize,
  output logic [1:0]            axim_awburst,
  output logic                  axim_awlock,
  output logic [3:0]            axim_awcache,
  output logic [2:0]            axim_awprot,
  output logic [3:0]            axim_awqos,
  output logic [3:0]            axim_awregion,
  output logic                  axim_awvalid,
  input  logic                  axim_awready,
  output logic [ID_WIDTH-1:0]   axim_wid,
  output logic [DATA_WIDTH-1:0] axim_wdata,
  output logic [STRB_WIDTH-1:0] axim_wstrb,
  output logic                  axim_wlast,
  output logic                  axim_wvalid,
  input  logic                  axim_wready,
  input  logic [ID_WIDTH-1:0]   axim_bid,
  input  logic [1:0]            axim_bresp,
  input  logic                  axim_bvalid,
  output logic                  axim_bready,
  output logic [ID_WIDTH-1:0]   axim_arid,
  output logic [ADDR_WIDTH-1:0] axim_araddr,
  output logic [7:0]            axim_arlen,
  output logic [2:0]            axim_arsize,
  output logic [1:0]            axim_arburst,
  output logic                  axim_arlock,
  output logic [3:0]            axim_arcache,
  output logic [2:0]            axim_arprot,
  output logic [3:0]            axim_arqos,
  output logic [3:0]            axim_arregion,
  output logic                  axim_arvalid,
  input  logic                  axim_arready,
  input  logic [ID_WIDTH-1:0]   axim_rid,
  input  logic [DATA_WIDTH-1:0] axim_rdata,
  input  logic [1:0]            axim_rresp,
  input  logic                  axim_rlast,
  input  logic                  axim_rvalid,
  output logic                  axim_rready,
  output logic [7:0]            wr_ost_cnt,
  output logic [7:0]            rd_ost_cnt,
  output logic                  idle
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] wr_ost_q, wr_ost_d;
  logic [CNT_W-1:0] rd_ost_q, rd_ost_d;
  logic [CNT_W-1:0] w_credit_q, w_credit_d;
  logic             idle_q, idle_d;
  logic             aw_ok, w_ok, ar_ok;
  logic             aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  // Payloads are wired straight through; only valid/ready are gated.
  assign axim_awid     = axis_awid;
  assign axim_awaddr   = axis_awaddr;
  assign axim_awlen    = axis_awlen;
  assign axim_awsize   = axis_awsize;
  assign axim_awburst  = axis_awburst;
  assign axim_awlock   = axis_awlock;
  assign axim_awcache  = axis_awcache;
  assign axim_awprot   = axis_awprot;
  assign axim_awqos    = axis_awqos;
  assign axim_awregion = axis_awregion;
  assign axim_wid      = axis_wid;
  assign axim_wdata    = axis_wdata;
  assign axim_wstrb    = axis_wstrb;
  assign axim_wlast    = axis_wlast;
  assign axis_bid      = axim_bid;
  assign axis_bresp    = axim_bresp;
  assign axis_bvalid   = axim_bvalid;
  assign axim_bready   = axis_bready;
  assign axim_arid     = axis_arid;
  assign axim_araddr   = axis_araddr;
  assign axim_arlen    = axis_arlen;
  assign axim_arsize   = axis_arsize;
  assign axim_arburst  = axis_arburst;
  assign axim_arlock   = axis_arlock;
  assign axim_arcache  = axis_arcache;
  assign axim_arprot   = axis_arprot;
  assign axim_arqos    = axis_arqos;
  assign axim_arregion = axis_arregion;
  assign axis_rid      = axim_rid;
  assign axis_rdata    = axim_rdata;
  assign axis_rresp    = axim_rresp;
  assign axis_rlast    = axim_rlast;
  assign axis_rvalid   = axim_rvalid;
  assign axim_rready   = axis_rready;

  // Gates close only through a handshake on their own channel, keeping valids stable.
  assign aw_ok = !arst && (wr_ost_q < CNT_W'(MAX_WR_OST));
  assign ar_ok = !arst && (rd_ost_q < CNT_W'(MAX_RD_OST));
  assign w_ok  = (w_credit_q != '0);

  assign axim_awvalid = axis_awvalid & aw_ok;
  assign axis_awready = axim_awready & aw_ok;
  assign axim_arvalid = axis_arvalid & ar_ok;
  assign axis_arready = axim_arready & ar_ok;
  assign axim_wvalid  = axis_wvalid & w_ok;
  assign axis_wready  = axim_wready & w_ok;

  assign aw_hs     = axis_awvalid & axis_awready;
  assign w_last_hs = axim_wvalid & axim_wready & axis_wlast;
  assign b_hs      = axim_bvalid & axis_bready;
  assign ar_hs     = axis_arvalid & axis_arready;
  assign r_last_hs = axim_rvalid & axis_rready & axim_rlast;

  always_comb begin
    wr_ost_d   = wr_ost_q;
    rd_ost_d   = rd_ost_q;
    w_credit_d = w_credit_q;
    if (aw_hs && !b_hs)
      wr_ost_d = wr_ost_q + CNT_W'(1);
    else if (b_hs && !aw_hs && (wr_ost_q != '0))
      wr_ost_d = wr_ost_q - CNT_W'(1);
    if (ar_hs && !r_last_hs)
      rd_ost_d = rd_ost_q + CNT_W'(1);
    else if (r_last_hs && !ar_hs && (rd_ost_q != '0))
      rd_ost_d = rd_ost_q - CNT_W'(1);
    if (aw_hs && !w_last_hs)
      w_credit_d = w_credit_q + CNT_W'(1);
    else if (w_last_hs && !aw_hs && (w_credit_q != '0))
      w_credit_d = w_credit_q - CNT_W'(1);
    idle_d = (wr_ost_d == '0) && (rd_ost_d == '0) && (w_credit_d == '0);
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_ost_q   <= '0;
      rd_ost_q   <= '0;
      w_credit_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      wr_ost_q   <= wr_ost_d;
      rd_ost_q   <= rd_ost_d;
      w_credit_q <= w_credit_d;
      idle_q     <= idle_d;
    end
  end

  assign wr_ost_cnt = wr_ost_q;
  assign rd_ost_cnt = rd_ost_q;
  assign idle       = idle_q;

`ifndef SYNTHESIS
  // A response with nothing outstanding means the far side broke protocol.
  a_wr_underflow: assert property (@(posedge aclk) disable iff (arst)
    !(b_hs && !aw_hs && (wr_ost_q == '0)))
    else $error("B handshake with no outstanding write");
  a_rd_underflow: assert property (@(posedge aclk) disable iff (arst)
    !(r_last_hs && !ar_hs && (rd_ost_q == '0)))
    else $error("R last handshake with no outstanding read");
`endif

endmodule
